asyn_fifo: RTL and testbench



---
 rtl/asyn_fifo.sv | 38 +++
 tb/tb_asyn_fifo.sv | 84 ++++++++
 2 files changed

// File: rtl/asyn_fifo.sv
// asyn_fifo: single-clock FIFO with wrap-bit pointers and registered read data
module asyn_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  full,
  output logic                  empty
);
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  logic [ADDR_WIDTH:0] wr_ptr, rd_ptr;
  logic wr_ok, rd_ok;
  assign empty = wr_ptr == rd_ptr;
  assign full = (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]) && (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]);
  assign wr_ok = wr_en && !full;
  assign rd_ok = rd_en && !empty;
  // storage array, unreset; writes are suppressed while reset is held
  always_ff @(posedge clk)
    if (rst_n && wr_ok) mem[wr_ptr[ADDR_WIDTH-1:0]] <= wr_data;
  // pointers and the registered read word
  always_ff @(posedge clk)
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      rd_data <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) begin
        rd_data <= mem[rd_ptr[ADDR_WIDTH-1:0]];
        rd_ptr  <= rd_ptr + 1'b1;
      end
    end
endmodule

// File: tb/tb_asyn_fifo.sv
// tb_asyn_fifo: directed and random stimulus against a queue-based reference model
module tb_asyn_fifo;
  logic clk = 0, rst_n = 0, wr_en = 1, rd_en = 1;
  logic [7:0] wr_data = 0, rd_data;
  logic full, empty;
  int errors = 0, checks = 0;
  logic [7:0] q[$];
  logic [7:0] exp_rd = 0;

  asyn_fifo dut (.clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data),
                 .rd_en(rd_en), .rd_data(rd_data), .full(full), .empty(empty));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit rs, input bit w, input logic [7:0] d, input bit r, input string tag);
    bit wa, ra;
    rst_n = !rs; wr_en = w; wr_data = d; rd_en = r;
    wa = w && q.size() < 16;
    ra = r && q.size() > 0;
    @(posedge clk);
    #1;
    if (rs) begin
      q.delete();
      exp_rd = 0;
    end else begin
      if (ra) exp_rd = q.pop_front();
      if (wa) q.push_back(d);
    end
    chk({tag, ".rd_data"}, rd_data, exp_rd);
    chk({tag, ".empty"}, empty, q.size() == 0);
    chk({tag, ".full"}, full, q.size() == 16);
  endtask

  initial begin
    step(1, 1, 8'hFF, 1, "reset0");
    step(1, 1, 8'hFE, 1, "reset1");
    step(0, 0, 8'h00, 0, "idle");
    for (int i = 1; i <= 16; i++) step(0, 1, 8'(i), 0, "fill");
    step(0, 1, 8'hAA, 0, "overflow");
    for (int i = 1; i <= 16; i++) begin
      step(0, 0, 8'h00, 1, "drain");
      chk("drain.order", rd_data, i);
    end
    step(0, 0, 8'h00, 1, "underflow");
    chk("underflow.hold", rd_data, 8'h10);
    for (int i = 0; i < 10; i++) step(0, 1, 8'($urandom), 0, "wrap.w10");
    for (int i = 0; i < 10; i++) step(0, 0, 8'h00, 1, "wrap.r10");
    for (int i = 0; i < 16; i++) step(0, 1, 8'(8'h20 + i), 0, "wrap.fill");
    chk("wrap.full", full, 1);
    for (int i = 0; i < 16; i++) begin
      step(0, 0, 8'h00, 1, "wrap.drain");
      chk("wrap.order", rd_data, 8'h20 + i);
    end
    for (int i = 0; i < 5; i++) step(0, 1, 8'($urandom), 0, "sim.pre");
    for (int i = 0; i < 8; i++) begin
      step(0, 1, 8'($urandom), 1, "sim.both");
      chk("sim.occ", q.size(), 5);
    end
    for (int i = 0; i < 5; i++) step(0, 0, 8'h00, 1, "sim.drain");
    step(0, 1, 8'h77, 1, "empty.both");
    chk("empty.nobypass", rd_data, exp_rd);
    step(0, 0, 8'h00, 1, "empty.read");
    chk("empty.word", rd_data, 8'h77);
    for (int i = 0; i < 7; i++) step(0, 1, 8'($urandom), 0, "mid.fill");
    step(1, 0, 8'h00, 0, "mid.reset");
    chk("mid.rd0", rd_data, 0);
    step(0, 1, 8'h55, 0, "mid.w");
    step(0, 0, 8'h00, 1, "mid.r");
    chk("mid.rd55", rd_data, 8'h55);
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 59) == 0, $urandom_range(0, 2) != 0, 8'($urandom),
           $urandom_range(0, 2) != 0, "rand");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
